// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared types for the parallel-in / serial-out serializer.
//   state_t : serializer FSM state (IDLE = shifter empty, SHIFT = bits on line)
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Serializes WIDTH-bit words onto a one-bit link.  The link paces the
//   output with ser_en.  A one-word hold buffer sits in front of the shifter.
//   This lets the next word follow the current one with no idle cycle.
//
// Parameters
//   WIDTH     : parallel word width in bits (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   in_data   in   parallel word
//   in_valid  in   in_data valid
//   in_ready  out  a word can be accepted this cycle (hold buffer empty)
//   ser_en    in   bit-advance strobe from the link
//   ser_out   out  current serial bit (0 when ser_valid = 0)
//   ser_valid out  ser_out carries a data bit
//   ser_last  out  ser_out is the final bit of the current word
//   busy      out  shifter or hold buffer occupied
// ---------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_advance;
    logic             w_last_adv;
    logic             w_head;
    logic [WIDTH-1:0] w_shift_next;

    // in_ready depends only on the hold flag. This keeps it free of any
    // combinational path from in_valid.
    assign w_accept   = in_valid & ~r_hold_full;
    assign w_advance  = (r_state == SHIFT) & ser_en;
    assign w_last_adv = w_advance & (r_count == LAST_IDX);

    // The bit on the line is always at the outgoing end of the shifter.
    // Each advance moves the next bit into that position.
    always_comb begin
        w_head       = 1'b0;
        w_shift_next = '0;
        if (MSB_FIRST != 0) begin
            w_head       = r_shift[WIDTH-1];
            w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin
            w_head       = r_shift[0];
            w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The hold buffer is always empty in IDLE. An accepted
                    // word therefore loads straight into the shifter.
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_count <= '0;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_last_adv) begin
                        // Word boundary. Refill the shifter from the hold
                        // buffer first, then from a word arriving on this
                        // same edge. If neither exists, go idle.
                        r_count <= '0;
                        if (r_hold_full) begin
                            r_shift     <= r_hold;
                            r_hold_full <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= in_data;
                        end else begin
                            r_shift <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_advance) begin
                            r_shift <= w_shift_next;
                            r_count <= r_count + 1'b1;
                        end
                        if (w_accept) begin
                            r_hold      <= in_data;
                            r_hold_full <= 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = ~r_hold_full;
    assign ser_valid = (r_state == SHIFT);
    assign ser_out   = ser_valid & w_head;
    assign ser_last  = ser_valid & (r_count == LAST_IDX);
    assign busy      = ser_valid | r_hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Drives the same stimulus into an MSB-first and an LSB-first instance.
//   Both are checked against a word-level model: a current word with a bit
//   index, plus a one-entry hold queue.  A word scoreboard rebuilds each
//   serialized word and compares it with the accepted words, in order.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         ser_en;

    logic m_ready, m_out, m_valid, m_last, m_busy;
    logic l_ready, l_out, l_valid, l_last, l_busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .ser_en(ser_en), .ser_out(m_out),
        .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .ser_en(ser_en), .ser_out(l_out),
        .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model ----
    bit           mv;
    logic [W-1:0] mword;
    int           midx;
    logic [W-1:0] mhold[$];
    logic [W-1:0] accq[$];

    // bits seen on the line
    logic [W-1:0]  m_col, l_col;
    logic [31:0]   m_stream, l_stream;

    function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
        logic [W-1:0] t;
        t = w;
        return msb ? t[W-1-idx] : t[idx];
    endfunction

    task automatic model_clear();
        mv = 0; mword = '0; midx = 0;
        mhold.delete(); accq.delete();
        m_col = '0; l_col = '0;
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] d, input bit en);
        bit acc, consumed, was_valid;
        acc       = v && (mhold.size() == 0);
        consumed  = 0;
        was_valid = mv;
        if (acc) accq.push_back(d);
        if (mv && en) begin
            if (midx == W-1) begin
                if (mhold.size() > 0) begin
                    mword = mhold.pop_front(); midx = 0;
                end else if (acc) begin
                    mword = d; midx = 0; consumed = 1;
                end else begin
                    mv = 0;
                end
            end else begin
                midx++;
            end
        end
        if (acc && !consumed) begin
            if (!was_valid) begin
                mv = 1; mword = d; midx = 0;
            end else begin
                mhold.push_back(d);
            end
        end
    endtask

    task automatic check_outputs();
        bit e_last, e_rdy, e_busy;
        e_last = mv && (midx == W-1);
        e_rdy  = (mhold.size() == 0);
        e_busy = mv || !e_rdy;
        chk("m_valid", m_valid, mv);
        chk("l_valid", l_valid, mv);
        chk("m_last",  m_last,  e_last);
        chk("l_last",  l_last,  e_last);
        chk("m_ready", m_ready, e_rdy);
        chk("l_ready", l_ready, e_rdy);
        chk("m_busy",  m_busy,  e_busy);
        chk("l_busy",  l_busy,  e_busy);
        chk("m_out",   m_out,   mv ? exp_bit(mword, midx, 1) : 1'b0);
        chk("l_out",   l_out,   mv ? exp_bit(mword, midx, 0) : 1'b0);
    endtask

    // One clock cycle. Entered and left just after a falling edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit en);
        logic [W-1:0] expw;
        in_valid = v; in_data = d; ser_en = en;
        check_outputs();
        if (m_valid && en) begin
            m_col    = {m_col[W-2:0], m_out};
            l_col    = {l_out, l_col[W-1:1]};
            m_stream = {m_stream[30:0], m_out};
            l_stream = {l_stream[30:0], l_out};
            if (m_last) begin
                if (accq.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    expw = accq.pop_front();
                    chk("word_m", m_col, expw);
                    chk("word_l", l_col, expw);
                end
            end
        end
        @(posedge clk);
        model_edge(v, d, en);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; ser_en = 1'b0; in_data = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_m_out",   m_out,   1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last",  m_last,  1'b0);
        chk("rst_m_busy",  m_busy,  1'b0);
        chk("rst_m_ready", m_ready, 1'b1);
        chk("rst_l_valid", l_valid, 1'b0);
        chk("rst_l_busy",  l_busy,  1'b0);
        chk("rst_l_ready", l_ready, 1'b1);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit rdy_before;
        rst = 1'b0;
        m_stream = '0; l_stream = '0;
        apply_reset();

        // single word, continuous ser_en; first edge after reset accepts
        m_stream = '0; l_stream = '0;
        step(1, 4'b1011, 1);
        repeat (5) step(0, '0, 1);
        chk("seq_msb_1011", m_stream[3:0], 4'b1011);
        chk("seq_lsb_1011", l_stream[3:0], 4'b1101);

        // back-to-back words
        m_stream = '0;
        step(1, 4'hA, 1);
        step(1, 4'h5, 1);
        repeat (9) step(0, '0, 1);
        chk("seq_A5", m_stream[7:0], 8'hA5);

        // third word stalls while hold is full, then goes through
        m_stream = '0;
        step(1, 4'h1, 1);
        step(1, 4'h2, 1);
        for (int i = 0; i < 12; i++) begin
            rdy_before = (mhold.size() == 0);
            step(1, 4'h3, 1);
            if (rdy_before) break;
        end
        repeat (8) step(0, '0, 1);
        chk("seq_123", m_stream[11:0], 12'h123);

        // ser_en every other cycle
        m_stream = '0;
        step(1, 4'b0110, 0);
        for (int i = 0; i < 10; i++) step(0, '0, (i % 2) == 1);
        repeat (2) step(0, '0, 1);
        chk("seq_0110", m_stream[3:0], 4'b0110);

        // reset after two bits with a word held
        step(1, 4'hF, 1);
        step(1, 4'h9, 1);
        step(0, '0, 1);
        apply_reset();
        repeat (6) step(0, '0, 1);

        // randomized traffic, one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset();
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (12) step(0, '0, 1);
        chk("sb_drained", accq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits (WIDTH >= 2).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 ser_en  input  1  bit-advance strobe from the link.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out carries a data bit.
REQ-011 ser_last  output  1  ser_out is the final bit of the current word.
REQ-012 busy  output  1  shifter or hold buffer occupied.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge SHALL accept.
REQ-014 in_ready SHALL equal NOT hold_full, with no combinational dependence on in_valid.
REQ-015 Two-state FSM: IDLE (shifter empty, ser_valid=0) and SHIFT (ser_valid=1).
REQ-016 IDLE with hold empty: an accepted word SHALL load directly into the shifter, bit count 0, next state SHIFT; ser_valid goes high the cycle after acceptance.
REQ-017 SHIFT: an accepted word SHALL go to the hold buffer, setting hold_full.
REQ-018 A bit SHALL advance only on an edge with ser_valid=1 and ser_en=1; with ser_en=0, ser_out, count and ser_last SHALL hold.
REQ-019 Bit count SHALL be $clog2(WIDTH) bits wide, 0 to WIDTH-1, and SHALL not wrap within a word.
REQ-020 ser_last SHALL be 1 exactly when ser_valid=1 and count=WIDTH-1.
REQ-021 Last bit advanced with hold full: the hold word SHALL load into the shifter, hold_full cleared, state stays SHIFT, no idle cycle on ser_valid.
REQ-022 Last bit advanced with hold empty and a simultaneous acceptance: the accepted word SHALL load directly into the shifter, state stays SHIFT, no gap.
REQ-023 Last bit advanced with hold empty and no acceptance: state SHALL go to IDLE, ser_valid=0 next cycle.
REQ-024 While ser_valid=0, ser_out SHALL be 0.
REQ-025 busy SHALL equal ser_valid OR hold_full.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, hold_full=0, count=0, shift and hold registers to 0, ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
REQ-027 Reset mid-word SHALL discard the partial and held words; nothing resumes after release.
REQ-028 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and no other items.
REQ-030 Single module, no sub-module; counter, hold buffer and shifter are inline.

Verification (WIDTH=4 unless noted)
REQ-031 MSB_FIRST=1, send 4'b1011, ser_en=1 held -> ser_out 1,0,1,1 on consecutive cycles; ser_last only on the 4th; ser_valid low next cycle.
REQ-032 Back-to-back 4'hA then 4'h5, ser_en=1 -> 8 contiguous bits 1010 0101; in_ready=0 while hold is full.
REQ-033 Third word offered while shifter and hold are full -> in_ready=0; the word is stalled, not lost, and is accepted right after the hold buffer empties.
REQ-034 ser_en high every other cycle, word 4'b0110 -> each bit held 2 cycles; ser_last is high for 2 cycles.
REQ-035 MSB_FIRST=0, word 4'b1011 -> ser_out 1,1,0,1.
REQ-036 rst asserted after 2 bits of 4'hF with a word in hold -> all outputs 0 and in_ready=1 immediately; after release, ser_valid stays 0 until a new acceptance.
